// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions (x^16+x^15+x^2+1, MSB-first, 32 bits per step).
// Used by the receive checker and the transmit-side generator.
package crc16_pkg;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'h8005;

  typedef enum logic {
    IDLE,
    DATA
  } state_t;

  // Data bit 31 is shifted in first.
  function automatic logic [15:0] crc16_d32(
    input logic [15:0] crc,
    input logic [31:0] data
  );
    logic [15:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data[i])
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else
        c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_d32_step.sv
// One 32-bit CRC-16 step as a combinational block.
// Shared between the checker and the generator.
module crc16_d32_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [31:0] data,
  output logic [15:0] crc_next
);

  assign crc_next = crc16_d32(crc, data);

endmodule

// File: rtl/crc16_frame_check.sv
// Receive-side CRC-16 frame checker: strips the CRC word, forwards
// payload through a one-word hold register and reports per-frame status.
module crc16_frame_check
  import crc16_pkg::*;
#(
  parameter int MAX_WORDS = 512,
  parameter int CNT_W     = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [31:0]      iData,
  input  logic             iValid,
  input  logic             iSop,
  input  logic             iEop,
  input  logic             iCntClr,
  output logic [31:0]      oData,
  output logic             oValid,
  output logic             oSop,
  output logic             oEop,
  output logic             oDone,
  output logic             oCrcOk,
  output logic             oErr,
  output logic [15:0]      oCrcCalc,
  output logic [15:0]      oFrmLen,
  output logic [CNT_W-1:0] oFrmCnt,
  output logic [CNT_W-1:0] oErrCnt
);

  localparam logic [31:0] MAX_W = MAX_WORDS;

  state_t      state;
  logic [15:0] crc;
  logic [15:0] crc_seed;
  logic [15:0] crc_next;
  logic [15:0] wcnt;
  logic [15:0] wcnt_inc;
  logic [31:0] hold;
  logic        hold_sop;
  logic        lenerr;
  logic        crc_match;

  // A sop always restarts the CRC, even when it aborts a running frame.
  assign crc_seed = (iSop || state == IDLE) ? CRC16_INIT : crc;

  crc16_d32_step u_step (
    .crc      (crc_seed),
    .data     (iData),
    .crc_next (crc_next)
  );

  assign wcnt_inc  = (wcnt == 16'hFFFF) ? wcnt : wcnt + 16'd1;
  assign lenerr    = {16'd0, wcnt} > MAX_W;
  assign crc_match = iData[15:0] == crc;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      crc      <= CRC16_INIT;
      wcnt     <= 16'd0;
      hold     <= 32'd0;
      hold_sop <= 1'b0;
      oData    <= 32'd0;
      oValid   <= 1'b0;
      oSop     <= 1'b0;
      oEop     <= 1'b0;
      oDone    <= 1'b0;
      oCrcOk   <= 1'b0;
      oErr     <= 1'b0;
      oCrcCalc <= 16'd0;
      oFrmLen  <= 16'd0;
    end else begin
      oValid <= 1'b0;
      oSop   <= 1'b0;
      oEop   <= 1'b0;
      oDone  <= 1'b0;
      if (iValid) begin
        unique case (state)
          IDLE: begin
            if (iSop && iEop) begin
              oDone    <= 1'b1;
              oCrcOk   <= iData[15:0] == CRC16_INIT;
              oErr     <= iData[15:0] != CRC16_INIT;
              oCrcCalc <= CRC16_INIT;
              oFrmLen  <= 16'd0;
            end else if (iSop) begin
              crc      <= crc_next;
              hold     <= iData;
              hold_sop <= 1'b1;
              wcnt     <= 16'd1;
              state    <= DATA;
            end
          end
          DATA: begin
            // In DATA the hold register always carries a payload word.
            oValid <= 1'b1;
            oData  <= hold;
            oSop   <= hold_sop;
            if (iSop) begin
              oEop     <= 1'b1;
              oDone    <= 1'b1;
              oCrcOk   <= 1'b0;
              oErr     <= 1'b1;
              oCrcCalc <= crc;
              oFrmLen  <= wcnt;
              if (iEop) begin
                state <= IDLE;
              end else begin
                crc      <= crc_next;
                hold     <= iData;
                hold_sop <= 1'b1;
                wcnt     <= 16'd1;
              end
            end else if (iEop) begin
              oEop     <= 1'b1;
              oDone    <= 1'b1;
              oCrcOk   <= crc_match;
              oErr     <= !crc_match || lenerr;
              oCrcCalc <= crc;
              oFrmLen  <= wcnt;
              state    <= IDLE;
            end else begin
              crc      <= crc_next;
              hold     <= iData;
              hold_sop <= 1'b0;
              wcnt     <= wcnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Statistics follow the registered oDone; a clear in that cycle wins.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oFrmCnt <= '0;
      oErrCnt <= '0;
    end else if (iCntClr) begin
      oFrmCnt <= '0;
      oErrCnt <= '0;
    end else if (oDone) begin
      if (oFrmCnt != '1)
        oFrmCnt <= oFrmCnt + 1'b1;
      if (oErr && oErrCnt != '1)
        oErrCnt <= oErrCnt + 1'b1;
    end
  end

endmodule

// File: doc/crc16_frame_check.md
Name: crc16_frame_check

Overview:
- Receive-side checker for 32-bit word frames protected by the team's CRC-16 (poly 1+x^2+x^15+x^16, init 0xFFFF, 32 data bits per step).
- The final word of each frame (the eop word) carries the transmitted CRC in [15:0].
- The block recomputes the CRC over the payload words, strips the CRC word, forwards the payload with eop re-marked on the last payload word, and reports pass/fail per frame plus statistics.
- It sits between the port receive datapath and the switch ingress buffer.

Parameters:
- MAX_WORDS, 512, max payload words per frame; more than this flags a length error.
- CNT_W, 16, width of the frame and error statistics counters.

Ports:
- iClk  in  1  clock
- iRst_n  in  1  async active-low reset
- iData  in  32  frame word
- iValid  in  1  word valid (no backpressure; a word is accepted every cycle iValid=1)
- iSop  in  1  first word of frame, qualified by iValid
- iEop  in  1  last word (CRC word), qualified by iValid
- iCntClr  in  1  synchronous clear of statistics counters
- oData  out  32  forwarded payload word
- oValid  out  1  payload valid
- oSop  out  1  payload first word
- oEop  out  1  payload last word
- oDone  out  1  one-cycle pulse: frame check result valid
- oCrcOk  out  1  valid with oDone: received CRC equals computed CRC
- oErr  out  1  valid with oDone: CRC mismatch, length error or protocol abort
- oCrcCalc  out  16  computed CRC; holds its value until the next oDone
- oFrmLen  out  16  payload word count of the reported frame; holds
- oFrmCnt  out  CNT_W  frames reported, saturating
- oErrCnt  out  CNT_W  frames reported with oErr=1, saturating

Behaviour:
- Reset (async, iRst_n=0): state IDLE, CRC register 0xFFFF, hold register empty. All outputs 0.
- States:
  - IDLE: wait for iValid&iSop. Words without sop are discarded silently.
  - DATA: frame in progress.
- Payload handling:
  - A sop or subsequent non-eop word is a payload word. Its update is CRC <= f(CRC, iData); the CRC register is reloaded to 0xFFFF at each sop before folding.
  - Payload words are delayed through a one-word hold register.
  - When a new payload word arrives, the held word is emitted (oValid=1) on the next cycle.
  - The first emitted word of a frame carries oSop=1.
- Eop word (CRC word):
  - Not folded into the CRC and not emitted. iData[31:16] is ignored.
  - On the next cycle: the held word (if any) is emitted with oEop=1; oDone=1; oCrcOk=(iData[15:0]==CRC); oErr=!oCrcOk|lenerr; oCrcCalc and oFrmLen are updated. State returns to IDLE.
  - Latency: eop accepted at cycle N gives oDone at N+1.
- sop&eop on the same word: zero-payload frame. Nothing is emitted; the compare is against 0xFFFF; oFrmLen=0.
- Length: a 16-bit word counter saturates. Payload count > MAX_WORDS sets lenerr; forwarding continues.
- sop while in DATA (abort):
  - The held word is emitted with oEop=1.
  - oDone=1 with oCrcOk=0, oErr=1.
  - The new frame starts in the same cycle (CRC reload, then fold).
- Back-to-back frames (eop at N, sop at N+1) run with no bubble.
- Counters: oFrmCnt+1 on every oDone; oErrCnt+1 on oDone&oErr; both saturate at all-ones. iCntClr zeroes them; an increment in the same cycle is lost (clear wins).
- Gaps (iValid=0) mid-frame are allowed; state and hold register are unchanged.
- Reset mid-frame: frame dropped, no oDone, counters zeroed.

Decomposition:
- Shared package crc16_pkg holds:
  - CRC16_INIT=16'hFFFF
  - function crc16_d32(crc[15:0], data[31:0]), the single 32-bit-step next-state equation set shared with the transmit-side generator
  - state enum IDLE/DATA
- Sub-module: crc16_d32_step, a combinational wrapper of the function. It is optional and reusable by the generator; the checker instantiates one.

Test Plan:
- Zero-payload frame: single word sop=eop=1, iData=0x1234FFFF -> N+1: oDone=1, oCrcOk=1, oErr=0, oFrmLen=0, oCrcCalc=0xFFFF, no oValid.
- 4-word payload 0x01020304..0x0D0E0F10, CRC word = golden crc16_d32 chain -> 4 oValid words, oSop on word 1, oEop on word 4 coincident with oDone, oCrcOk=1, oFrmLen=4. The same frame with CRC bit 0 flipped -> oErr=1, oErrCnt=1.
- Frame of 3 payload words with iValid gaps of 2 cycles between words -> output identical to the gap-free case except timing; oCrcOk=1.
- sop arrives after 2 payload words without eop -> oEop on word 2, oDone with oErr=1. The new frame then completes correctly: oFrmCnt=2, oErrCnt=1.
- MAX_WORDS=4 build, 5-word payload with correct CRC -> oCrcOk=1, oErr=1, oFrmLen=5.
- Counter saturation with CNT_W=2: 5 frames -> oFrmCnt=3. iCntClr together with oDone -> both counters 0. iRst_n low mid-frame -> no oDone, all outputs 0.
